// File: rtl/sa_request_gen.sv
// Switch-allocation request stage: per input picks one credit-eligible VC round-robin, requests its output port, consumes grants.
// Latency: request->pop 0 cycles (combinational on grants); grant->xbar_valid 1 cycle; credit_in->eligibility 1 cycle.
// Backpressure: a VC whose downstream (output, out-VC) counter is 0 is never requested; credits return via credit_in pulses.
module sa_request_gen #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_VCS   = 2,
    parameter int BUF_DEPTH = 4,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*NUM_VCS-1:0]    vc_valid,
    input  logic [NUM_PORTS*NUM_VCS*PW-1:0] vc_route,
    input  logic [NUM_PORTS*NUM_VCS*VW-1:0] vc_outvc,
    input  logic [NUM_PORTS*NUM_VCS-1:0]    credit_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  grants,
    output logic [NUM_PORTS*NUM_PORTS-1:0]  requests,
    output logic [NUM_PORTS*NUM_VCS-1:0]    pop,
    output logic [NUM_PORTS-1:0]            xbar_valid,
    output logic [NUM_PORTS*PW-1:0]         xbar_sel,
    output logic                            credit_err
);

    // Unpacked views of the flat input buses
    logic [PW-1:0]        route_a   [NUM_PORTS][NUM_VCS];
    logic [VW-1:0]        outvc_a   [NUM_PORTS][NUM_VCS];

    // Registered state
    logic [CW-1:0]        credit_q  [NUM_PORTS][NUM_VCS];
    logic [VW-1:0]        rr_ptr_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0] xbar_valid_q;
    logic [PW-1:0]        xbar_sel_q [NUM_PORTS];
    logic                 credit_err_q;

    // Combinational selection / grant decode
    logic [NUM_VCS-1:0]   elig      [NUM_PORTS];
    logic [NUM_PORTS-1:0] has_req;
    logic [VW-1:0]        sel       [NUM_PORTS];
    logic [VW-1:0]        next_ptr  [NUM_PORTS];
    logic [PW-1:0]        sel_route [NUM_PORTS];
    logic [VW-1:0]        sel_outvc [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_row   [NUM_PORTS];
    logic [NUM_PORTS-1:0] win;
    logic [NUM_VCS-1:0]   debit     [NUM_PORTS];
    logic [NUM_PORTS-1:0] xbar_set;
    logic [PW-1:0]        xbar_src  [NUM_PORTS];

    // Slice flat buses and mark VCs that hold a flit and have a downstream credit
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                route_a[p][v] = vc_route[(p*NUM_VCS+v)*PW +: PW];
                outvc_a[p][v] = vc_outvc[(p*NUM_VCS+v)*VW +: VW];
                elig[p][v]    = vc_valid[p*NUM_VCS+v] &&
                                (credit_q[route_a[p][v]][outvc_a[p][v]] != '0);
            end
        end
    end

    // Round-robin pick: first eligible VC starting at rr_ptr, wrapping
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            has_req[p] = 1'b0;
            sel[p]     = '0;
            for (int k = 0; k < NUM_VCS; k++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    if (!has_req[p] && elig[p][v] &&
                        (v == (int'(rr_ptr_q[p]) + k) % NUM_VCS)) begin
                        has_req[p] = 1'b1;
                        sel[p]     = VW'(v);
                    end
                end
            end
            sel_route[p] = route_a[p][sel[p]];
            sel_outvc[p] = outvc_a[p][sel[p]];
            next_ptr[p]  = (sel[p] == VW'(NUM_VCS - 1)) ? '0 : sel[p] + 1'b1;
        end
    end

    // Request rows and grant matching; a grant only counts when it equals a non-empty request row
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_row[p] = '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                req_row[p][o] = reset && has_req[p] && (sel_route[p] == PW'(o));
            end
            win[p] = (req_row[p] != '0) &&
                     (grants[p*NUM_PORTS +: NUM_PORTS] == req_row[p]);
        end
    end

    // Per-output effects of the winners: credit debit and crossbar source
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            debit[o]    = '0;
            xbar_set[o] = 1'b0;
            xbar_src[o] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (win[p] && (sel_route[p] == PW'(o))) begin
                    xbar_set[o] = 1'b1;
                    xbar_src[o] = PW'(p);
                    for (int v = 0; v < NUM_VCS; v++) begin
                        if (sel_outvc[p] == VW'(v)) begin
                            debit[o][v] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Flatten outputs
    always_comb begin
        requests = '0;
        pop      = '0;
        xbar_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            requests[p*NUM_PORTS +: NUM_PORTS] = req_row[p];
            xbar_sel[p*PW +: PW]               = xbar_sel_q[p];
            for (int v = 0; v < NUM_VCS; v++) begin
                pop[p*NUM_VCS+v] = win[p] && (sel[p] == VW'(v));
            end
        end
    end

    assign xbar_valid = xbar_valid_q;
    assign credit_err = credit_err_q;

    // Downstream credit counters; simultaneous debit and return cancel out, a return at full credit is an error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    credit_q[o][v] <= CW'(BUF_DEPTH);
                end
            end
            credit_err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    case ({debit[o][v], credit_in[o*NUM_VCS+v]})
                        2'b10: begin
                            if (credit_q[o][v] != '0) begin
                                credit_q[o][v] <= credit_q[o][v] - 1'b1;
                            end
                        end
                        2'b01: begin
                            if (credit_q[o][v] == CW'(BUF_DEPTH)) begin
                                credit_err_q <= 1'b1;
                            end else begin
                                credit_q[o][v] <= credit_q[o][v] + 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Round-robin pointers advance past the winning VC only on a matched grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rr_ptr_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (win[p]) begin
                    rr_ptr_q[p] <= next_ptr[p];
                end
            end
        end
    end

    // Crossbar configuration for next-cycle traversal; select holds when an output idles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xbar_valid_q <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                xbar_sel_q[o] <= '0;
            end
        end else begin
            xbar_valid_q <= xbar_set;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xbar_set[o]) begin
                    xbar_sel_q[o] <= xbar_src[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_request_gen.sv
module tb_sa_request_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vc_valid;
    logic [15:0] vc_route;
    logic [7:0]  vc_outvc;
    logic [7:0]  credit_in;
    logic [15:0] grants;
    logic [15:0] requests;
    logic [7:0]  pop;
    logic [3:0]  xbar_valid;
    logic [7:0]  xbar_sel;
    logic        credit_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sa_request_gen #(.NUM_PORTS(4), .NUM_VCS(2), .BUF_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .vc_valid   (vc_valid),
        .vc_route   (vc_route),
        .vc_outvc   (vc_outvc),
        .credit_in  (credit_in),
        .grants     (grants),
        .requests   (requests),
        .pop        (pop),
        .xbar_valid (xbar_valid),
        .xbar_sel   (xbar_sel),
        .credit_err (credit_err)
    );

    task automatic clear_inputs();
        vc_valid  = '0;
        vc_route  = '0;
        vc_outvc  = '0;
        credit_in = '0;
        grants    = '0;
    endtask

    task automatic set_vc(input int p, input int v, input int r, input int ov);
        vc_valid[p*2+v]        = 1'b1;
        vc_route[(p*2+v)*2 +: 2] = r[1:0];
        vc_outvc[p*2+v]        = ov[0];
    endtask

    // Reset state with live inputs present
    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        set_vc(0, 0, 1, 0);
        grants[1] = 1'b1;
        #12;
        total++; if (requests !== 16'h0) begin bad++; $display("FAIL reset_requests got=%h exp=%h", requests, 16'h0); end
        total++; if (pop !== 8'h0) begin bad++; $display("FAIL reset_pop got=%h exp=%h", pop, 8'h0); end
        total++; if (xbar_valid !== 4'h0) begin bad++; $display("FAIL reset_xbar_valid got=%h exp=%h", xbar_valid, 4'h0); end
        total++; if (xbar_sel !== 8'h0) begin bad++; $display("FAIL reset_xbar_sel got=%h exp=%h", xbar_sel, 8'h0); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%b exp=%b", credit_err, 1'b0); end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
    endtask

    // Two VCs of input 0 to output 2, grant always: VC0, VC1, VC0
    task automatic test_rr();
        logic [7:0] exp_pop;
        @(negedge clk);
        clear_inputs();
        set_vc(0, 0, 2, 0);
        set_vc(0, 1, 2, 1);
        grants[2] = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_pop = (i == 1) ? 8'h02 : 8'h01;
            total++; if (requests[3:0] !== 4'b0100) begin bad++; $display("FAIL rr_request i=%0d got=%h exp=%h", i, requests[3:0], 4'b0100); end
            total++; if (pop !== exp_pop) begin bad++; $display("FAIL rr_pop i=%0d got=%h exp=%h", i, pop, exp_pop); end
            @(negedge clk);
            total++; if (xbar_valid !== 4'b0100) begin bad++; $display("FAIL rr_xbar_valid i=%0d got=%h exp=%h", i, xbar_valid, 4'b0100); end
            total++; if (xbar_sel[5:4] !== 2'd0) begin bad++; $display("FAIL rr_xbar_sel i=%0d got=%0d exp=0", i, xbar_sel[5:4]); end
        end
        clear_inputs();
        @(negedge clk);
        total++; if (xbar_valid !== 4'b0000) begin bad++; $display("FAIL rr_xbar_idle got=%h exp=%h", xbar_valid, 4'b0000); end
        total++; if (xbar_sel[5:4] !== 2'd0) begin bad++; $display("FAIL rr_xbar_sel_hold got=%0d exp=0", xbar_sel[5:4]); end
    endtask

    // Input 1 VC0 to (3,0): four pops, starve, one credit -> one more pop
    task automatic test_credit_exhaust();
        clear_inputs();
        set_vc(1, 0, 3, 0);
        grants[7] = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++; if (pop[2] !== (i < 4)) begin bad++; $display("FAIL exhaust_pop i=%0d got=%b exp=%b", i, pop[2], (i < 4)); end
            total++; if (requests[7:4] !== ((i < 4) ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL exhaust_req i=%0d got=%h", i, requests[7:4]); end
            @(negedge clk);
        end
        credit_in[6] = 1'b1;
        #1;
        total++; if (requests[7:4] !== 4'b0000) begin bad++; $display("FAIL exhaust_credit_latency got=%h exp=%h", requests[7:4], 4'b0000); end
        @(negedge clk);
        credit_in[6] = 1'b0;
        #1;
        total++; if (requests[7:4] !== 4'b1000) begin bad++; $display("FAIL exhaust_refill_req got=%h exp=%h", requests[7:4], 4'b1000); end
        total++; if (pop !== 8'h04) begin bad++; $display("FAIL exhaust_refill_pop got=%h exp=%h", pop, 8'h04); end
        @(negedge clk);
        #1;
        total++; if (requests[7:4] !== 4'b0000) begin bad++; $display("FAIL exhaust_empty_again got=%h exp=%h", requests[7:4], 4'b0000); end
        @(negedge clk);
        clear_inputs();
    endtask

    // (3,0) at credit 2 gets a debit and a return together: still two pops left afterwards
    task automatic test_simultaneous();
        credit_in[6] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_vc(1, 0, 3, 0);
        grants[7] = 1'b1;
        #1;
        total++; if (pop[2] !== 1'b1) begin bad++; $display("FAIL simul_pop got=%b exp=1", pop[2]); end
        @(negedge clk);
        credit_in[6] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (pop[2] !== (i < 2)) begin bad++; $display("FAIL simul_after i=%0d got=%b exp=%b", i, pop[2], (i < 2)); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    // All inputs want output 0; only the granted one pops
    task automatic test_contention();
        for (int p = 0; p < 4; p++) begin
            set_vc(p, 0, 0, 0);
            set_vc(p, 1, 0, 0);
        end
        grants[9] = 1'b1;
        #1;
        total++; if (requests !== 16'h1111) begin bad++; $display("FAIL cont_requests got=%h exp=%h", requests, 16'h1111); end
        total++; if (pop !== 8'h00) begin bad++; $display("FAIL cont_unmatched_pop got=%h exp=%h", pop, 8'h00); end
        @(negedge clk);
        total++; if (xbar_valid !== 4'b0000) begin bad++; $display("FAIL cont_unmatched_xbar got=%h exp=%h", xbar_valid, 4'b0000); end
        grants = '0;
        grants[8] = 1'b1;
        #1;
        total++; if (pop !== 8'h10) begin bad++; $display("FAIL cont_pop_p2 got=%h exp=%h", pop, 8'h10); end
        @(negedge clk);
        total++; if (xbar_valid !== 4'b0001) begin bad++; $display("FAIL cont_xbar_valid got=%h exp=%h", xbar_valid, 4'b0001); end
        total++; if (xbar_sel[1:0] !== 2'd2) begin bad++; $display("FAIL cont_xbar_sel_p2 got=%0d exp=2", xbar_sel[1:0]); end
        grants = '0;
        grants[0] = 1'b1;
        #1;
        total++; if (pop !== 8'h02) begin bad++; $display("FAIL cont_pop_p0 got=%h exp=%h", pop, 8'h02); end
        @(negedge clk);
        total++; if (xbar_sel[1:0] !== 2'd0) begin bad++; $display("FAIL cont_xbar_sel_p0 got=%0d exp=0", xbar_sel[1:0]); end
        grants = '0;
        grants[12] = 1'b1;
        #1;
        total++; if (pop !== 8'h40) begin bad++; $display("FAIL cont_pop_p3 got=%h exp=%h", pop, 8'h40); end
        @(negedge clk);
        total++; if (xbar_sel[1:0] !== 2'd3) begin bad++; $display("FAIL cont_xbar_sel_p3 got=%0d exp=3", xbar_sel[1:0]); end
        grants = '0;
        grants[4] = 1'b1;
        #1;
        total++; if (pop !== 8'h08) begin bad++; $display("FAIL cont_pop_p1 got=%h exp=%h", pop, 8'h08); end
        @(negedge clk);
        total++; if (xbar_sel[1:0] !== 2'd1) begin bad++; $display("FAIL cont_xbar_sel_p1 got=%0d exp=1", xbar_sel[1:0]); end
        clear_inputs();
    endtask

    // Return on an empty counter is fine; return on a full counter is sticky error
    task automatic test_overflow();
        credit_in[0] = 1'b1;
        @(negedge clk);
        credit_in[0] = 1'b0;
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL ovf_legal_return got=%b exp=0", credit_err); end
        credit_in[1] = 1'b1;
        @(negedge clk);
        credit_in[1] = 1'b0;
        total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", credit_err); end
        repeat (3) @(negedge clk);
        total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", credit_err); end
    endtask

    // Reset asserted mid-stream clears everything at once; afterwards full credits and rr from VC0
    task automatic test_reset_midstream();
        int npop;
        clear_inputs();
        set_vc(0, 0, 1, 0);
        set_vc(0, 1, 1, 1);
        grants[1] = 1'b1;
        #1;
        total++; if (pop !== 8'h01) begin bad++; $display("FAIL mid_pre_pop got=%h exp=%h", pop, 8'h01); end
        @(negedge clk);
        total++; if (xbar_valid !== 4'b0010) begin bad++; $display("FAIL mid_pre_xbar got=%h exp=%h", xbar_valid, 4'b0010); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (xbar_valid !== 4'b0000) begin bad++; $display("FAIL mid_xbar_valid got=%h exp=%h", xbar_valid, 4'b0000); end
        total++; if (requests !== 16'h0) begin bad++; $display("FAIL mid_requests got=%h exp=%h", requests, 16'h0); end
        total++; if (pop !== 8'h00) begin bad++; $display("FAIL mid_pop got=%h exp=%h", pop, 8'h00); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL mid_credit_err got=%b exp=0", credit_err); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (pop !== 8'h01) begin bad++; $display("FAIL mid_rr_restart got=%h exp=%h", pop, 8'h01); end
        npop = 0;
        for (int i = 0; i < 10; i++) begin
            npop += int'(pop[0]) + int'(pop[1]);
            @(negedge clk);
        end
        total++; if (npop != 8) begin bad++; $display("FAIL mid_credit_restore got=%0d exp=8", npop); end
        total++; if (requests[3:0] !== 4'b0000) begin bad++; $display("FAIL mid_drained got=%h exp=%h", requests[3:0], 4'b0000); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_rr();
        test_credit_exhaust();
        test_simultaneous();
        test_contention();
        test_overflow();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
